// File: rtl/instr_fetch_line_buffer.sv
// Single-line instruction fetch buffer on a fixed-latency 128-bit line memory port.
// Optional next-line prefetch buffer is enabled with `define NEXT_LINE_PREFETCH_EN.
module instr_fetch_line_buffer #(
   parameter int MEM_LATENCY = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [31:0]   pc_i,
   input  logic          req_i,
   input  logic          flush_i,
   output logic [31:0]   instr_o,
   output logic          instr_valid_o,
   output logic          stall_o,
   output logic [31:0]   mem_addr_o,
   input  logic [127:0]  mem_line_i
);

   localparam int CW = $clog2(MEM_LATENCY + 1);

`ifdef NEXT_LINE_PREFETCH_EN
   typedef enum logic [1:0] {S_IDLE, S_FILL, S_PREFETCH, S_SWAP} state_t;
`else
   typedef enum logic [0:0] {S_IDLE, S_FILL} state_t;
`endif

   state_t          state_q;
   logic [127:0]    line_q;
   logic [27:0]     tag_q;
   logic            line_valid_q;
   logic [27:0]     fill_tag_q;
   logic [CW-1:0]   cnt_q;
   logic [31:0]     mem_addr_q;
`ifdef NEXT_LINE_PREFETCH_EN
   logic [127:0]    pf_line_q;
   logic [27:0]     pf_tag_q;
   logic            pf_valid_q;
`endif

   logic [27:0]     pc_tag;
   logic            hit;
   logic            miss;
   logic            cap;
   logic            unused_pc;

   assign pc_tag    = pc_i[31:4];
   assign unused_pc = ^pc_i[1:0];
   assign cap       = (cnt_q == CW'(MEM_LATENCY - 1));

`ifdef NEXT_LINE_PREFETCH_EN
   assign hit = line_valid_q && (tag_q == pc_tag) && !flush_i && (state_q != S_SWAP);
`else
   assign hit = line_valid_q && (tag_q == pc_tag) && !flush_i;
`endif

   assign miss          = req_i && !hit && !flush_i;
   assign instr_valid_o = req_i && hit;
   assign stall_o       = req_i && !instr_valid_o;
   assign instr_o       = line_q[{pc_i[3:2], 5'b00000} +: 32];
   assign mem_addr_o    = mem_addr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         line_q       <= '0;
         tag_q        <= '0;
         line_valid_q <= 1'b0;
         fill_tag_q   <= '0;
         cnt_q        <= '0;
         mem_addr_q   <= '0;
`ifdef NEXT_LINE_PREFETCH_EN
         pf_line_q    <= '0;
         pf_tag_q     <= '0;
         pf_valid_q   <= 1'b0;
`endif
      end else if (flush_i) begin
         // flush beats a capture edge landing in the same cycle
         state_q      <= S_IDLE;
         line_valid_q <= 1'b0;
         cnt_q        <= '0;
`ifdef NEXT_LINE_PREFETCH_EN
         pf_valid_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (miss) begin
`ifdef NEXT_LINE_PREFETCH_EN
                  if (pf_valid_q && (pf_tag_q == pc_tag)) begin
                     line_q       <= pf_line_q;
                     tag_q        <= pf_tag_q;
                     line_valid_q <= 1'b1;
                     pf_valid_q   <= 1'b0;
                     state_q      <= S_SWAP;
                  end else begin
                     pf_valid_q   <= 1'b0;
                     mem_addr_q   <= {pc_tag, 4'h0};
                     fill_tag_q   <= pc_tag;
                     cnt_q        <= '0;
                     state_q      <= S_FILL;
                  end
`else
                  mem_addr_q <= {pc_tag, 4'h0};
                  fill_tag_q <= pc_tag;
                  cnt_q      <= '0;
                  state_q    <= S_FILL;
`endif
               end
            end
            S_FILL: begin
               if (req_i && (pc_tag != fill_tag_q)) begin
                  mem_addr_q <= {pc_tag, 4'h0};
                  fill_tag_q <= pc_tag;
                  cnt_q      <= '0;
               end else if (cap) begin
                  line_q       <= mem_line_i;
                  tag_q        <= fill_tag_q;
                  line_valid_q <= 1'b1;
                  cnt_q        <= '0;
`ifdef NEXT_LINE_PREFETCH_EN
                  mem_addr_q   <= {fill_tag_q + 28'd1, 4'h0};
                  pf_tag_q     <= fill_tag_q + 28'd1;
                  pf_valid_q   <= 1'b0;
                  state_q      <= S_PREFETCH;
`else
                  state_q      <= S_IDLE;
`endif
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
`ifdef NEXT_LINE_PREFETCH_EN
            S_PREFETCH: begin
               if (miss && (pc_tag == pf_tag_q)) begin
                  // demand for the line already in flight: keep the running count
                  fill_tag_q <= pf_tag_q;
                  if (cap) begin
                     line_q       <= mem_line_i;
                     tag_q        <= pf_tag_q;
                     line_valid_q <= 1'b1;
                     cnt_q        <= '0;
                     mem_addr_q   <= {pf_tag_q + 28'd1, 4'h0};
                     pf_tag_q     <= pf_tag_q + 28'd1;
                     state_q      <= S_PREFETCH;
                  end else begin
                     cnt_q   <= cnt_q + CW'(1);
                     state_q <= S_FILL;
                  end
               end else if (miss) begin
                  pf_valid_q <= 1'b0;
                  mem_addr_q <= {pc_tag, 4'h0};
                  fill_tag_q <= pc_tag;
                  cnt_q      <= '0;
                  state_q    <= S_FILL;
               end else if (cap) begin
                  pf_line_q  <= mem_line_i;
                  pf_valid_q <= 1'b1;
                  cnt_q      <= '0;
                  state_q    <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_SWAP: begin
               mem_addr_q <= {tag_q + 28'd1, 4'h0};
               pf_tag_q   <= tag_q + 28'd1;
               cnt_q      <= '0;
               state_q    <= S_PREFETCH;
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
